// File: rtl/thumb_fetch_buffer.sv
// thumb_fetch_buffer: Thumb halfword prefetch buffer between a 32-bit instruction
// memory and the decode stage. Fetches whole words, splits them into halfwords
// tagged with their PC, and presents one halfword per cycle at the head.
// Optional feature: define FETCH_PAIR_HOLD_EN to hold back the first half of a
// 32-bit instruction until its second half is buffered.
module thumb_fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    input  logic        imem_valid_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic [15:0] instruction_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    output logic        is_32bit_first_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [15:0]   hw_mem [DEPTH];
    logic [31:0]   pc_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_ptr_p1;
    logic [CW-1:0] count;
    logic [31:0]   fetch_addr;
    logic [31:0]   req_addr_q;
    logic          req_q;
    logic          skip_lo_q;
    logic          req_ok;
    logic          push;
    logic          pop;
    logic          valid_int;
    logic [CW-1:0] push_n;
    logic [CW-1:0] pop_n;

    // Halfword alignment of the redirect target is carried by bit 1 only.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = redirect_pc_i[0];

    // Circular pointer advance that also works for non power-of-two depths.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
        int s;
        s = int'(p) + n;
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    // Request only when this word plus any word already in flight still fits.
    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        req_ok = 1'b0;
        if (!flush_i && (int'(count) + (req_q ? 2 : 0) + 2 <= DEPTH)) req_ok = 1'b1;
    end

    assign imem_req_o  = req_ok & rst_n_i;
    assign imem_addr_o = fetch_addr;

    // A response is accepted only for a request issued last cycle and not flushed since.
    assign push      = imem_valid_i && req_q && !flush_i;
    assign push_n    = push ? (skip_lo_q ? CW'(1) : CW'(2)) : '0;
    assign pop       = valid_int && !stall_i && !flush_i;
    assign pop_n     = CW'(pop);
    assign wr_ptr_p1 = ptr_add(wr_ptr, 1);

    // Head entry is shown whenever the buffer holds anything; zero when empty.
    always_comb begin
        instruction_o = 16'h0000;
        instr_pc_o    = 32'h0000_0000;
        if (count != '0) begin
            instruction_o = hw_mem[rd_ptr];
            instr_pc_o    = pc_mem[rd_ptr];
        end
    end

    assign is_32bit_first_o = (instruction_o[15:13] == 3'b111) && (instruction_o[12:11] != 2'b00);

`ifdef FETCH_PAIR_HOLD_EN
    logic second_half_q;

    // Remember that the head is the trailing half of a 32-bit pair just started.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            second_half_q <= 1'b0;
        end else if (flush_i) begin
            second_half_q <= 1'b0;
        end else if (pop) begin
            second_half_q <= is_32bit_first_o && !second_half_q;
        end
    end

    assign valid_int = (count != '0) &&
                       !(is_32bit_first_o && !second_half_q && (count < CW'(2)));
`else
    assign valid_int = (count != '0);
`endif

    assign instr_valid_o = valid_int;

    // Control state: pointers, occupancy, fetch address and in-flight tracking.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            fetch_addr <= {RESET_PC[31:2], 2'b00};
            req_addr_q <= '0;
            req_q      <= 1'b0;
            skip_lo_q  <= RESET_PC[1];
        end else if (flush_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            fetch_addr <= {redirect_pc_i[31:2], 2'b00};
            req_q      <= 1'b0;
            skip_lo_q  <= redirect_pc_i[1];
        end else begin
            if (pop)  rd_ptr <= ptr_add(rd_ptr, 1);
            if (push) wr_ptr <= ptr_add(wr_ptr, int'(push_n));
            count <= count + push_n - pop_n;
            req_q <= req_ok;
            if (req_ok) begin
                fetch_addr <= fetch_addr + 32'd4;
                req_addr_q <= fetch_addr;
            end
            if (push) skip_lo_q <= 1'b0;
        end
    end

    // Write one or two halfwords of an accepted response into the ring.
    // NOTE: the storage array is not reset; count gates every read, so stale entries never show.
    always_ff @(posedge clk_i) begin
        if (push) begin
            if (skip_lo_q) begin
                hw_mem[wr_ptr] <= imem_data_i[31:16];
                pc_mem[wr_ptr] <= req_addr_q + 32'd2;
            end else begin
                hw_mem[wr_ptr]    <= imem_data_i[15:0];
                pc_mem[wr_ptr]    <= req_addr_q;
                hw_mem[wr_ptr_p1] <= imem_data_i[31:16];
                pc_mem[wr_ptr_p1] <= req_addr_q + 32'd2;
            end
        end
    end

    // A push that would overrun the ring means the request throttle is broken.
    always @(posedge clk_i) begin
        if (rst_n_i && push) begin
            assert (int'(count) - int'(pop_n) + int'(push_n) <= DEPTH);
        end
    end

endmodule
